seg14_scroll_drv: RTL and testbench
===================================

# seg14_scroll_drv

Parametrised multiplexed 14-segment display driver with a writable message buffer and horizontal scrolling. It scans `N_DIGITS` common-select digits and shows a `N_DIGITS`-wide window onto a `MSG_LEN`-character message. The window can advance by one character at a programmable frame rate. It sits between a host/bus write port and the board's `sel`/`segm` pads, and is the generalised successor to the fixed-text 12-digit banner driver.

## Interface
- `N_DIGITS`, 12: number of scanned digits. Must be ≥ 1.
- `MSG_LEN`, 16: message buffer depth in characters. Must be ≥ `N_DIGITS`.
- `REFRESH_DIV`, 1: clocks per digit step. Must be ≥ 1.
- `SCROLL_DIV`, 4: frames per one-character scroll step. Must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset. Asynchronous, active-high.
- `wr_en` in 1: write strobe for the message buffer.
- `wr_addr` in $clog2(MSG_LEN): buffer index to write.
- `wr_char` in 6: character code to write.
- `scroll_en` in 1: enables scrolling.
- `blank` in 1: forces all segments off; scanning continues.
- `sel` out N_DIGITS: one-hot digit select. Bit 0 is the leftmost digit.
- `segm` out 14: segment pattern for the selected digit.
- `frame_tick` out 1: one-clock pulse, asserted in the cycle the last digit is driven.

## Operation
- Character codes:
  - 0–25 are A–Z.
  - 26–35 are digits 0–9.
  - 36 is space.
  - 37–63 are illegal and render as space (`segm`=0).
- Buffer:
  - `MSG_LEN` × 6-bit registers.
  - Reset to code 36 (all spaces).
  - A write with `wr_en`=1 updates the entry on the same clock edge.
  - If `wr_addr` ≥ `MSG_LEN`, the write is ignored.
- Prescaler:
  - `pre` counts 0..`REFRESH_DIV`-1.
  - `step` = (`pre`==`REFRESH_DIV`-1).
- Digit counter `dig`:
  - Ranges 0..`N_DIGITS`-1.
  - Increments on `step`.
  - Wraps from `N_DIGITS`-1 to 0.
- On each `step`, these outputs register together:
  - `sel` ← one-hot(`dig`).
  - `segm` ← `blank` ? 0 : font(msg[(`off`+`dig`) mod `MSG_LEN`]).
  - `frame_tick` ← (`dig`==`N_DIGITS`-1).
- Between steps, `sel` and `segm` hold their values. `frame_tick` is 0 in all other cycles.
- Read/write collision: the buffer is read combinationally from current register state. A write on the same edge as a `step` reading that address displays the old character; the new character appears on the next visit.
- Scroll offset `off`:
  - Ranges 0..`MSG_LEN`-1.
  - Frame counter `fc` ranges 0..`SCROLL_DIV`-1. It advances on each `step` with `dig`==`N_DIGITS`-1 while `scroll_en`=1.
  - When `fc`==`SCROLL_DIV`-1 on that step, `fc`←0 and `off`←(`off`+1) mod `MSG_LEN`. The offset wraps from `MSG_LEN`-1 to 0.
  - The new offset takes effect from digit 0 of the next frame. It never changes mid-frame.
  - When `scroll_en`=0, `fc` clears to 0 and `off` holds. Deasserting and reasserting `scroll_en` restarts the `SCROLL_DIV` count.
- Index arithmetic: sum width is $clog2(MSG_LEN)+1, with a single conditional subtraction of `MSG_LEN` (valid because `off`, `dig` < `MSG_LEN`).

## Timing
- Reset values: `sel`=0, `segm`=0, `frame_tick`=0, `pre`=`dig`=`off`=`fc`=0, buffer all spaces.
- Reset asserted mid-frame clears everything immediately (asynchronously) and drives `sel` to 0 the same instant.
- First `step` occurs `REFRESH_DIV` rising edges after `rst` falls. On that edge, `sel` becomes 1 (digit 0).
- Latency from `step` to pads: one edge (outputs are registered).
- A full frame is `N_DIGITS`×`REFRESH_DIV` clocks.
- `frame_tick` period equals the frame length.
- `blank` is sampled at each `step` and is therefore visible on the next digit load.

## Structure
- Package `seg14_pkg` holds:
  - `char_t` (6-bit) and the `CH_SPACE`=36 constant.
  - The 37-entry 14-bit font table. It must include these entries:
    - A = 14'b11101111000000
    - B = 14'b11110001010010
    - M = 14'b01101100101000
    - O = 14'b11111100000000
    - R = 14'b11001111000100
    - S = 14'b10110111000000
    - U = 14'b01111100000000
    - space = 0
  - Function `font(char_t)`, which returns 0 for codes > 36.
- One sub-module, `seg14_scan_timer`, generates `pre`/`dig`/`step`/last-digit. The buffer, offset and output registers stay in the top module.

## Test plan
- **Reset state:** assert `rst` mid-scan → `sel`=0, `segm`=0 and `frame_tick`=0 asynchronously. After release with `REFRESH_DIV`=1, the first edge gives `sel`=12'h001 and `segm`=0 (space).
- **Static text:** write "RAM BUS ROM " (17,0,12,36,1,20,18,36,17,14,12,36) to addresses 0–11, `scroll_en`=0 → digit 0 shows 14'b11001111000100, digit 2 shows 14'b01101100101000, digit 5 shows 14'b01111100000000. `sel` walks 12'h001→12'h800 and `frame_tick` pulses once per 12 clocks.
- **Scrolling and wrap:** `MSG_LEN`=16, `SCROLL_DIV`=2, `scroll_en`=1 → `off` increments every 24 clocks. After 16 increments `off`=0 again, and digit 11 at `off`=15 reads address 10.
- **Write collision:** write code 0 (A) to address 3 on the edge of digit 3's `step` → that frame shows space, the next frame shows 14'b11101111000000.
- **Refresh divide, blank and illegal code:** `REFRESH_DIV`=4, pulse `blank` → each digit is held for 4 clocks and `segm`=0 while `blank`=1. Writing code 50 displays 0.
- **Scroll gating:** toggle `scroll_en` low for one frame → `off` holds and `fc` restarts, so the next increment occurs `SCROLL_DIV` full frames after re-enable.

Source files
------------

// File: rtl/seg14_pkg.sv
// Shared types, character codes and the 14-segment font for the scrolling display driver.
// Segment order, MSB first: a b c d e f g1 g2 h i j k l m.
package seg14_pkg;

  typedef logic [5:0]  char_t;
  typedef logic [13:0] glyph_t;

  localparam char_t CH_SPACE = 6'd36;
  localparam int    N_GLYPHS = 37;

  // Codes 0-25 are A-Z, 26-35 are 0-9, 36 is space.
  localparam glyph_t FONT [0:N_GLYPHS-1] = '{
    14'b11101111000000, // A
    14'b11110001010010, // B
    14'b10011100000000, // C
    14'b11110000010010, // D
    14'b10011110000000, // E
    14'b10001110000000, // F
    14'b10111101000000, // G
    14'b01101111000000, // H
    14'b10010000010010, // I
    14'b01111000000000, // J
    14'b00001110001100, // K
    14'b00011100000000, // L
    14'b01101100101000, // M
    14'b01101100100100, // N
    14'b11111100000000, // O
    14'b11001111000000, // P
    14'b11111100000100, // Q
    14'b11001111000100, // R
    14'b10110111000000, // S
    14'b10000000010010, // T
    14'b01111100000000, // U
    14'b00001100001001, // V
    14'b01101100000101, // W
    14'b00000000101101, // X
    14'b00000000101010, // Y
    14'b10010000001001, // Z
    14'b11111100001001, // 0
    14'b01100000001000, // 1
    14'b11011011000000, // 2
    14'b11110011000000, // 3
    14'b01100111000000, // 4
    14'b10110111000000, // 5
    14'b10111111000000, // 6
    14'b11100000000000, // 7
    14'b11111111000000, // 8
    14'b11110111000000, // 9
    14'b00000000000000  // space
  };

  function automatic glyph_t font(input char_t c);
    return (c <= CH_SPACE) ? FONT[c] : '0;
  endfunction

endpackage

// File: rtl/seg14_scan_timer.sv
// Refresh prescaler and digit counter; produces the digit step strobe and
// flags the last digit of a frame.
module seg14_scan_timer #(
  parameter  int N_DIGITS    = 12,
  parameter  int REFRESH_DIV = 1,
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [DW-1:0] dig,
  output logic          step,
  output logic          last_dig
);

  logic [PW-1:0] pre;

  assign step     = (pre == PW'(REFRESH_DIV - 1));
  assign last_dig = (dig == DW'(N_DIGITS - 1));

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      dig <= '0;
    end else begin
      pre <= step ? '0 : pre + 1'b1;
      if (step) dig <= last_dig ? '0 : dig + 1'b1;
    end
  end

endmodule

// File: rtl/seg14_scroll_drv.sv
// Multiplexed 14-segment driver showing an N_DIGITS window onto a writable
// MSG_LEN-character message, with optional frame-paced horizontal scrolling.
module seg14_scroll_drv
  import seg14_pkg::*;
#(
  parameter  int N_DIGITS    = 12,
  parameter  int MSG_LEN     = 16,
  parameter  int REFRESH_DIV = 1,
  parameter  int SCROLL_DIV  = 4,
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1,
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [5:0]          wr_char,
  input  logic                scroll_en,
  input  logic                blank,
  output logic [N_DIGITS-1:0] sel,
  output logic [13:0]         segm,
  output logic                frame_tick
);

  logic [DW-1:0]       dig;
  logic                step;
  logic                last_dig;
  char_t               msg [MSG_LEN];
  logic [AW-1:0]       off;
  logic [SW-1:0]       fc;
  logic [AW:0]         sum;
  logic [AW:0]         idx;
  char_t               rd_char;
  logic [N_DIGITS-1:0] sel_next;

  seg14_scan_timer #(
    .N_DIGITS    (N_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .dig      (dig),
    .step     (step),
    .last_dig (last_dig)
  );

  // off and dig are both below MSG_LEN, so one conditional subtract wraps the sum.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_next      = '0;
    sel_next[dig] = 1'b1;
    sum           = {1'b0, off} + (AW+1)'(dig);
    idx           = (sum >= (AW+1)'(MSG_LEN)) ? sum - (AW+1)'(MSG_LEN) : sum;
    rd_char       = msg[idx[AW-1:0]];
  end

  // NOTE: the message buffer is deliberately reset so the display comes up blank
  // rather than showing whatever the registers powered up with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) msg[i] <= CH_SPACE;
    end else if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_LEN))) begin
      msg[wr_addr] <= wr_char;
    end
  end

  // The offset only moves on the last digit's step, so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off <= '0;
      fc  <= '0;
    end else if (!scroll_en) begin
      fc <= '0;
    end else if (step && last_dig) begin
      if (fc == SW'(SCROLL_DIV - 1)) begin
        fc  <= '0;
        off <= (off == AW'(MSG_LEN - 1)) ? '0 : off + 1'b1;
      end else begin
        fc <= fc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel        <= '0;
      segm       <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= step && last_dig;
      if (step) begin
        sel  <= sel_next;
        segm <= blank ? '0 : font(rd_char);
      end
    end
  end

endmodule

// File: tb/tb_seg14_scroll_drv.sv
// Scoreboard bench: two driver instances (REFRESH_DIV 1 and 4) checked every
// clock against a bench-side model, plus directed checks of the key behaviours.
module tb_seg14_scroll_drv;

  localparam int ND = 12;
  localparam int ML = 16;
  localparam logic [13:0] G_A = 14'b11101111000000;
  localparam logic [13:0] G_M = 14'b01101100101000;
  localparam logic [13:0] G_R = 14'b11001111000100;
  localparam logic [13:0] G_U = 14'b01111100000000;

  typedef struct {
    int          k;
    logic [11:0] sel;
    logic [13:0] segm;
    logic        ft;
  } exp_t;

  int rd [2] = '{1, 4};
  int sd [2] = '{2, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en     [2];
  logic [3:0]  wr_addr   [2];
  logic [5:0]  wr_char   [2];
  logic        scroll_en [2];
  logic        blank     [2];
  logic [11:0] sel       [2];
  logic [13:0] segm      [2];
  logic        ft        [2];

  int          m_msg  [2][ML];
  int          m_pre  [2];
  int          m_dig  [2];
  int          m_off  [2];
  int          m_fc   [2];
  logic [11:0] m_sel  [2];
  logic [13:0] m_segm [2];
  exp_t        sb [$];
  int          ft_cnt [2];
  int          n_cmp = 0;
  int          n_mis = 0;

  always #5 clk = ~clk;

  seg14_scroll_drv #(.N_DIGITS(ND), .MSG_LEN(ML), .REFRESH_DIV(1), .SCROLL_DIV(2)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_char(wr_char[0]),
    .scroll_en(scroll_en[0]), .blank(blank[0]), .sel(sel[0]), .segm(segm[0]),
    .frame_tick(ft[0]));

  seg14_scroll_drv #(.N_DIGITS(ND), .MSG_LEN(ML), .REFRESH_DIV(4), .SCROLL_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_char(wr_char[1]),
    .scroll_en(scroll_en[1]), .blank(blank[1]), .sel(sel[1]), .segm(segm[1]),
    .frame_tick(ft[1]));

  // Only the glyphs this bench displays; everything else it writes is blank.
  function automatic logic [13:0] bfont(input int c);
    case (c)
      0:       return G_A;
      1:       return 14'b11110001010010;
      12:      return G_M;
      14:      return 14'b11111100000000;
      17:      return G_R;
      18:      return 14'b10110111000000;
      20:      return G_U;
      default: return 14'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < ML; a++) m_msg[k][a] = 36;
      m_pre[k]  = 0;
      m_dig[k]  = 0;
      m_off[k]  = 0;
      m_fc[k]   = 0;
      m_sel[k]  = '0;
      m_segm[k] = '0;
    end
  endtask

  // Push the expected outputs for the coming edge, advance the model, then
  // pop and compare after the edge.
  task automatic cycle();
    exp_t e;
    bit   st;
    for (int k = 0; k < 2; k++) begin
      st = (m_pre[k] == rd[k] - 1);
      if (st) begin
        m_sel[k]  = 12'(1) << m_dig[k];
        m_segm[k] = blank[k] ? 14'b0 : bfont(m_msg[k][(m_off[k] + m_dig[k]) % ML]);
      end
      e.k    = k;
      e.sel  = m_sel[k];
      e.segm = m_segm[k];
      e.ft   = st && (m_dig[k] == ND - 1);
      sb.push_back(e);
      if (wr_en[k] && int'(wr_addr[k]) < ML) m_msg[k][wr_addr[k]] = int'(wr_char[k]);
      if (!scroll_en[k]) m_fc[k] = 0;
      else if (st && m_dig[k] == ND - 1) begin
        if (m_fc[k] == sd[k] - 1) begin
          m_fc[k]  = 0;
          m_off[k] = (m_off[k] + 1) % ML;
        end else m_fc[k]++;
      end
      if (st) m_dig[k] = (m_dig[k] + 1) % ND;
      m_pre[k] = st ? 0 : m_pre[k] + 1;
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("d%0d_sel", e.k),  14'(sel[e.k]),  14'(e.sel));
      check($sformatf("d%0d_segm", e.k), segm[e.k],      e.segm);
      check($sformatf("d%0d_tick", e.k), 14'(ft[e.k]),   14'(e.ft));
      if (ft[e.k] === 1'b1) ft_cnt[e.k]++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Advance until the next edge is instance k's step for digit d.
  task automatic run_to_step(input int k, input int d);
    int g = 0;
    while (!(m_pre[k] == rd[k] - 1 && m_dig[k] == d) && g < 200) begin
      cycle();
      g++;
    end
    if (g >= 200) begin
      n_cmp++;
      n_mis++;
      $error("FAIL to_step: observed timeout expected digit %0d", d);
    end
  endtask

  initial begin
    int txt [12] = '{17, 0, 12, 36, 1, 20, 18, 36, 17, 14, 12, 36};
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wr_en[k] = 1'b0; wr_addr[k] = '0; wr_char[k] = '0;
      scroll_en[k] = 1'b0; blank[k] = 1'b0; ft_cnt[k] = 0;
    end
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      check("rst_sel",  14'(sel[k]), 14'(0));
      check("rst_segm", segm[k],     14'(0));
      check("rst_tick", 14'(ft[k]),  14'(0));
    end

    @(posedge clk); #1;
    rst = 1'b0;
    cycle();
    check("first_sel",  14'(sel[0]), 14'h001);
    check("first_segm", segm[0],     14'(0));
    run(5);

    // Asynchronous reset mid-scan.
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("arst_sel",  14'(sel[k]), 14'(0));
      check("arst_segm", segm[k],     14'(0));
      check("arst_tick", 14'(ft[k]),  14'(0));
    end
    @(posedge clk); #1;
    check("rst_hold_sel", 14'(sel[0]), 14'(0));
    rst = 1'b0;
    model_reset();
    run(3);
    check("rd4_not_yet", 14'(sel[1]), 14'(0));
    cycle();
    check("rd4_first", 14'(sel[1]), 14'h001);

    // Static text into both instances.
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 2; k++) begin
        wr_en[k] = 1'b1; wr_addr[k] = 4'(i); wr_char[k] = 6'(txt[i]);
      end
      cycle();
    end
    for (int k = 0; k < 2; k++) wr_en[k] = 1'b0;
    run(12);
    ft_cnt[0] = 0;
    run(24);
    check("tick_per_24", 14'(ft_cnt[0]), 14'(2));
    run_to_step(0, 0); cycle();
    check("dig0_R", segm[0], G_R);
    check("dig0_sel", 14'(sel[0]), 14'h001);
    run_to_step(0, 2); cycle();
    check("dig2_M", segm[0], G_M);
    run_to_step(0, 5); cycle();
    check("dig5_U", segm[0], G_U);
    run_to_step(0, 11); cycle();
    check("dig11_sel", 14'(sel[0]), 14'h800);

    // Write collides with the step that reads the same address.
    run_to_step(0, 3);
    wr_en[0] = 1'b1; wr_addr[0] = 4'd3; wr_char[0] = 6'd0;
    cycle();
    wr_en[0] = 1'b0;
    check("coll_old", segm[0], 14'(0));
    run_to_step(0, 3); cycle();
    check("coll_new", segm[0], G_A);

    // Scroll through a full wrap; digit 11 at offset 15 shows address 10 (M).
    scroll_en[0] = 1'b1;
    for (int i = 0; i < 17 * 24; i++) begin
      bit f;
      f = (m_off[0] == 15 && m_dig[0] == 11);
      cycle();
      if (f) check("wrap_d11_M", segm[0], G_M);
    end

    // Gate scrolling off for one frame, then resume.
    run_to_step(0, 0);
    scroll_en[0] = 1'b0;
    run(12);
    scroll_en[0] = 1'b1;
    run(72);

    // Slow instance: digit hold, blank and an illegal code.
    run_to_step(1, 1); cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rd4_hold", 14'(sel[1]), 14'h002);
    end
    blank[1] = 1'b1;
    run(8);
    check("blank_segm", segm[1], 14'(0));
    blank[1] = 1'b0;
    wr_en[1] = 1'b1; wr_addr[1] = 4'd0; wr_char[1] = 6'd50;
    cycle();
    wr_en[1] = 1'b0;
    run_to_step(1, 0); cycle();
    check("illegal_sel",  14'(sel[1]), 14'h001);
    check("illegal_segm", segm[1],     14'(0));
    run(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
